// File: rtl/vdpu_pkg.sv
// Shared widths and the score/ID pair type used by the top-K selection block.
package vdpu_pkg;

    localparam int ID_WIDTH_DEF    = 20;
    localparam int SCORE_WIDTH_DEF = 32;

    typedef struct packed {
        logic signed [SCORE_WIDTH_DEF-1:0] score;
        logic [ID_WIDTH_DEF-1:0]           id;
    } topk_entry_t;

endpackage

// File: rtl/topk_cell.sv
// One slot of the sorted top-K list: keep, load the incoming entry, or shift down
// from the slot above, depending on where the incoming score lands.
module topk_cell
    import vdpu_pkg::*;
#(
    parameter int SCORE_WIDTH = SCORE_WIDTH_DEF,
    parameter int ID_WIDTH    = ID_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          ins_en,
    input  logic                          occupied,
    input  logic signed [SCORE_WIDTH-1:0] new_score,
    input  logic [ID_WIDTH-1:0]           new_id,
    input  logic                          upper_ins,
    input  logic signed [SCORE_WIDTH-1:0] upper_score,
    input  logic [ID_WIDTH-1:0]           upper_id,
    output logic                          ins_o,
    output logic signed [SCORE_WIDTH-1:0] score_o,
    output logic [ID_WIDTH-1:0]           id_o
);

    logic signed [SCORE_WIDTH-1:0] score_q;
    logic [ID_WIDTH-1:0]           id_q;

    // Strictly greater keeps earlier arrivals ahead on ties; an empty slot always accepts.
    assign ins_o   = ins_en && (!occupied || (new_score > score_q));
    assign score_o = score_q;
    assign id_o    = id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
            id_q    <= '0;
        end else if (clr) begin
            if (ins_o && !upper_ins) begin
                score_q <= new_score;
                id_q    <= new_id;
            end else begin
                score_q <= '0;
                id_q    <= '0;
            end
        end else if (ins_o) begin
            if (upper_ins) begin
                score_q <= upper_score;
                id_q    <= upper_id;
            end else begin
                score_q <= new_score;
                id_q    <= new_id;
            end
        end
    end

endmodule

// File: rtl/topk_select.sv
// Streaming top-K selector: collects scored vector IDs, then drains them best-first.
// Optional per-query statistics outputs are enabled by TOPK_SELECT_STATS_EN.
module topk_select
    import vdpu_pkg::*;
#(
    parameter int ID_WIDTH    = ID_WIDTH_DEF,
    parameter int K           = 8,
    parameter int SCORE_WIDTH = SCORE_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          valid_in,
    input  logic signed [SCORE_WIDTH-1:0] score_in,
    input  logic [ID_WIDTH-1:0]           id_in,
    input  logic                          last_in,
    output logic                          busy,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic signed [SCORE_WIDTH-1:0] res_score,
    output logic [ID_WIDTH-1:0]           res_id,
    output logic [$clog2(K)-1:0]          res_rank,
    output logic                          res_last,
    output logic                          done
`ifdef TOPK_SELECT_STATS_EN
    ,
    output logic [31:0]                   stat_seen,
    output logic [31:0]                   stat_dropped
`endif
);

    localparam int RW = $clog2(K);
    localparam int FW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t                        state_q;
    logic [RW-1:0]                 rank_q;
    logic [FW-1:0]                 fill_q;
    logic                          done_q;
    logic signed [SCORE_WIDTH-1:0] score_arr [K];
    logic [ID_WIDTH-1:0]           id_arr [K];
    logic [K-1:0]                  ins_vec;
    logic                          ins_en;
    logic                          xfer;

    // A start beat carrying valid data becomes the first entry of the new query.
    assign ins_en = valid_in && (start || (state_q == COLLECT));

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_slot
            logic                          upper_ins;
            logic signed [SCORE_WIDTH-1:0] upper_score;
            logic [ID_WIDTH-1:0]           upper_id;
            logic                          occupied;

            if (gi == 0) begin : g_head
                assign upper_ins   = 1'b0;
                assign upper_score = '0;
                assign upper_id    = '0;
            end else begin : g_body
                assign upper_ins   = ins_vec[gi-1];
                assign upper_score = score_arr[gi-1];
                assign upper_id    = id_arr[gi-1];
            end

            assign occupied = !start && (FW'(gi) < fill_q);

            topk_cell #(
                .SCORE_WIDTH(SCORE_WIDTH),
                .ID_WIDTH   (ID_WIDTH)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .clr        (start),
                .ins_en     (ins_en),
                .occupied   (occupied),
                .new_score  (score_in),
                .new_id     (id_in),
                .upper_ins  (upper_ins),
                .upper_score(upper_score),
                .upper_id   (upper_id),
                .ins_o      (ins_vec[gi]),
                .score_o    (score_arr[gi]),
                .id_o       (id_arr[gi])
            );
        end
    endgenerate

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DRAIN);
    assign res_rank  = rank_q;
    assign res_score = res_valid ? score_arr[rank_q] : '0;
    assign res_id    = res_valid ? id_arr[rank_q] : '0;
    assign res_last  = res_valid && ((FW'(rank_q) + FW'(1)) == fill_q);
    assign done      = done_q;
    assign xfer      = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rank_q  <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state_q <= COLLECT;
                rank_q  <= '0;
                fill_q  <= ins_en ? FW'(1) : '0;
            end else begin
                case (state_q)
                    IDLE: ;
                    COLLECT: begin
                        // Below K the last slot is always empty, so every beat lands somewhere.
                        if (valid_in && (fill_q != FW'(K)))
                            fill_q <= fill_q + FW'(1);
                        if (valid_in && last_in)
                            state_q <= DRAIN;
                    end
                    DRAIN: begin
                        if (xfer) begin
                            if (res_last) begin
                                state_q <= IDLE;
                                rank_q  <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                rank_q <= rank_q + RW'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef TOPK_SELECT_STATS_EN
    logic [31:0] seen_q;
    logic [31:0] dropped_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q    <= '0;
            dropped_q <= '0;
        end else if (start) begin
            seen_q    <= valid_in ? 32'd1 : 32'd0;
            dropped_q <= '0;
        end else begin
            if (ins_en && (seen_q != '1))
                seen_q <= seen_q + 32'd1;
            if (valid_in && (state_q != COLLECT) && (dropped_q != '1))
                dropped_q <= dropped_q + 32'd1;
        end
    end

    assign stat_seen    = seen_q;
    assign stat_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_topk_select.sv
// Directed, table-driven bench for topk_select (K=8); stats checks build with TOPK_SELECT_STATS_EN.
module tb_topk_select;
    import vdpu_pkg::*;

    localparam int K  = 8;
    localparam int SW = 32;
    localparam int IW = 20;

    logic                 clk = 1'b0;
    logic                 rst, start, valid_in, last_in, res_ready;
    logic signed [SW-1:0] score_in;
    logic [IW-1:0]        id_in;
    logic                 busy, res_valid, res_last, done;
    logic signed [SW-1:0] res_score;
    logic [IW-1:0]        res_id;
    logic [$clog2(K)-1:0] res_rank;
`ifdef TOPK_SELECT_STATS_EN
    logic [31:0]          stat_seen, stat_dropped;
`endif

    typedef struct {
        logic signed [SW-1:0] score;
        logic [IW-1:0]        id;
        bit                   last;
        topk_entry_t          exp;
    } vec_t;

    vec_t tbl [32];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt++;

    topk_select #(.ID_WIDTH(IW), .K(K), .SCORE_WIDTH(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .valid_in (valid_in),
        .score_in (score_in),
        .id_in    (id_in),
        .last_in  (last_in),
        .busy     (busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_score(res_score),
        .res_id   (res_id),
        .res_rank (res_rank),
        .res_last (res_last),
        .done     (done)
`ifdef TOPK_SELECT_STATS_EN
        ,
        .stat_seen   (stat_seen),
        .stat_dropped(stat_dropped)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end else begin
            $display("ok   %s: %0d", name, $signed(act));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int i, input int s, input int id, input bit last,
                           input int es, input int eid);
        tbl[i].score     = s;
        tbl[i].id        = IW'(id);
        tbl[i].last      = last;
        tbl[i].exp.score = es;
        tbl[i].exp.id    = IW'(eid);
    endtask

    task automatic beat(input logic signed [SW-1:0] s, input logic [IW-1:0] id, input bit last);
        valid_in = 1'b1;
        score_in = s;
        id_in    = id;
        last_in  = last;
        step();
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_beats(input int n);
        start_pulse();
        for (int i = 0; i < n; i++) beat(tbl[i].score, tbl[i].id, tbl[i].last);
    endtask

    task automatic drain_check(input string tag, input int n);
        int t;
        res_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!res_valid && t < 20) begin
                step();
                t++;
            end
            check($sformatf("%s valid[%0d]", tag, i), 64'(res_valid), 64'd1);
            check($sformatf("%s score[%0d]", tag, i), 64'(res_score), 64'(tbl[i].exp.score));
            check($sformatf("%s id[%0d]", tag, i), 64'(res_id), 64'(tbl[i].exp.id));
            check($sformatf("%s rank[%0d]", tag, i), 64'(res_rank), 64'(i));
            check($sformatf("%s last[%0d]", tag, i), 64'(res_last), 64'(i == n - 1));
            step();
        end
        check({tag, " valid_after"}, 64'(res_valid), 64'd0);
        check({tag, " done_pulse"}, 64'(done), 64'd1);
        step();
        check({tag, " done_low"}, 64'(done), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
        res_ready = 1'b0;
    endtask

    task automatic load_q1();
        set_row(0, 5, 1, 0, 9, 2);
        set_row(1, 9, 2, 0, 9, 4);
        set_row(2, -3, 3, 0, 5, 1);
        set_row(3, 9, 4, 1, -3, 3);
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; last_in = 1'b0; res_ready = 1'b0;
        score_in = '0; id_in = '0;
        step();
        step();
        check("rst busy", 64'(busy), 64'd0);
        check("rst res_valid", 64'(res_valid), 64'd0);
        check("rst res_last", 64'(res_last), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst res_score", 64'(res_score), 64'd0);
        check("rst res_id", 64'(res_id), 64'd0);
        check("rst res_rank", 64'(res_rank), 64'd0);
        rst = 1'b0;

        // Beats in IDLE must be ignored.
        beat(50, 7, 0);
        beat(60, 8, 1);
        check("idle beats busy", 64'(busy), 64'd0);

        // Scenario: ties keep arrival order.
        load_q1();
        run_beats(4);
        check("q1 busy", 64'(busy), 64'd1);
`ifdef TOPK_SELECT_STATS_EN
        check("q1 stat_seen", 64'(stat_seen), 64'd4);
        check("q1 stat_dropped", 64'(stat_dropped), 64'd0);
`endif
        dc = done_cnt;
        drain_check("q1", 4);
        check("q1 done count", 64'(done_cnt), 64'(dc + 1));

        // Scenario: 20 ascending scores, only top 8 kept.
        for (int i = 0; i < 20; i++)
            set_row(i, i, i + 100, i == 19, (i < 8) ? 19 - i : 0, (i < 8) ? 119 - i : 0);
        run_beats(20);
        drain_check("asc", 8);

        // Full list: a score equal to the minimum, and one below it, are discarded.
        for (int i = 0; i < 8; i++) set_row(i, 10 + i, 200 + i, 0, 17 - i, 207 - i);
        set_row(8, 10, 300, 0, 0, 0);
        set_row(9, 9, 301, 1, 0, 0);
        run_beats(10);
        for (int i = 0; i < 8; i++) set_row(i, 0, 0, 0, 17 - i, 207 - i);
        drain_check("full", 8);

        // Backpressure: outputs hold, DRAIN ignores valid_in beats.
        load_q1();
        run_beats(4);
        for (int c = 0; c < 5; c++) begin
            valid_in = (c < 3);
            score_in = 100;
            id_in    = 99;
            check($sformatf("hold rank c%0d", c), 64'(res_rank), 64'd0);
            check($sformatf("hold score c%0d", c), 64'(res_score), 64'd9);
            check($sformatf("hold id c%0d", c), 64'(res_id), 64'd2);
            step();
        end
        valid_in = 1'b0;
`ifdef TOPK_SELECT_STATS_EN
        check("hold stat_dropped", 64'(stat_dropped), 64'd3);
        check("hold stat_seen", 64'(stat_seen), 64'd4);
`endif
        drain_check("bp", 4);

        // Abort mid-COLLECT: no done from the aborted query.
        dc = done_cnt;
        start_pulse();
        beat(10, 11, 0);
        beat(20, 12, 0);
        beat(30, 13, 0);
        start_pulse();
        check("abort done", 64'(done), 64'd0);
        check("abort busy", 64'(busy), 64'd1);
        check("abort res_valid", 64'(res_valid), 64'd0);
        beat(7, 9, 1);
        set_row(0, 7, 9, 1, 7, 9);
        drain_check("abort", 1);
        check("abort done count", 64'(done_cnt), 64'(dc + 1));

        // Reset during DRAIN, then a fresh query opened by start with valid data.
        load_q1();
        run_beats(4);
        check("rstd in drain", 64'(res_valid), 64'd1);
        dc = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstd busy", 64'(busy), 64'd0);
        check("rstd res_valid", 64'(res_valid), 64'd0);
        check("rstd res_score", 64'(res_score), 64'd0);
        check("rstd done", 64'(done), 64'd0);
        start = 1'b1;
        beat(3, 5, 0);
        start = 1'b0;
        beat(4, 6, 1);
        set_row(0, 0, 0, 0, 4, 6);
        set_row(1, 0, 0, 0, 3, 5);
        drain_check("fresh", 2);
        check("rstd done count", 64'(done_cnt), 64'(dc + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/topk_select.md
TOPK_SELECT -- requirements
Module: topk_select

Interface
REQ-001 Parameters: ID_WIDTH default 20, vector-ID width; K default 8, number of best scores retained, 2..32; SCORE_WIDTH default 32, signed score width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  pulse; clears the list and opens a new query.
REQ-005 valid_in  input  1  score_in/id_in/last_in are valid this cycle; no backpressure, never stalled.
REQ-006 score_in  input  SCORE_WIDTH  signed dot product from the tensor core.
REQ-007 id_in  input  ID_WIDTH  vector ID paired with score_in.
REQ-008 last_in  input  1  qualified by valid_in; final vector of the query.
REQ-009 busy  output  1  high in COLLECT or DRAIN.
REQ-010 res_valid / res_ready  output / input  1 / 1  result-stream handshake.
REQ-011 res_score / res_id / res_rank  output  SCORE_WIDTH / ID_WIDTH / $clog2(K)  current result entry; rank 0 is the best.
REQ-012 res_last  output  1  marks the final result entry.
REQ-013 done  output  1  one-cycle pulse after the final result transfers.

Function
REQ-014 FSM states: IDLE, COLLECT, DRAIN.
REQ-015 IDLE->COLLECT on start; valid_in is ignored in IDLE.
REQ-016 COLLECT: every valid_in beat is inserted; the sorted list and fill count update on the next edge, sustaining one insertion per cycle.
REQ-017 The list is held in descending signed order; a new score displaces an entry only if strictly greater, so on ties the earlier arrival ranks higher.
REQ-018 Fill count saturates at K; when the list is full, a score not greater than entry K-1 is discarded.
REQ-019 valid_in && last_in in COLLECT: the beat is inserted, then the FSM enters DRAIN on the next edge.
REQ-020 DRAIN: res_valid=1 from the first DRAIN cycle; entries are presented from rank 0 up to fill-1, advancing only on res_valid && res_ready.
REQ-021 If fewer than K scores arrived, only fill entries are drained; res_last=1 on rank fill-1.
REQ-022 On the transfer of the res_last entry: res_valid drops, done pulses the next cycle, and the FSM returns to IDLE.
REQ-023 Held outputs: res_score, res_id and res_rank stay stable while res_valid && !res_ready.
REQ-024 valid_in is ignored in DRAIN.
REQ-025 start in COLLECT or DRAIN aborts: the list is cleared, fill returns to 0, no done pulse, and the FSM enters COLLECT; start has priority over a simultaneous last_in or handshake.
REQ-026 start and valid_in together: the list clears and that beat is inserted as the first entry.

Reset
REQ-027 rst takes priority over all inputs, clears the FSM to IDLE, and clears fill and all list entries.
REQ-028 Output values during and after reset: busy=0, res_valid=0, res_last=0, done=0, res_score=0, res_id=0, res_rank=0.
REQ-029 rst mid-query discards the list without a done pulse.

Configuration
REQ-030 Macro TOPK_SELECT_STATS_EN.
REQ-031 With the macro defined, the block adds outputs stat_seen and stat_dropped, each 32 bits; both count per query, clear on start and rst, and saturate at all-ones.
REQ-032 stat_seen counts accepted COLLECT beats; stat_dropped counts valid_in beats ignored in IDLE or DRAIN.
REQ-033 Without the macro, these ports and counters do not exist; behaviour is otherwise identical.

Structure
REQ-034 Package vdpu_pkg holds the ID_WIDTH and SCORE_WIDTH defaults and typedef topk_entry_t {score, id}.
REQ-035 Sub-module topk_cell: one list slot that keeps, loads the new entry, or shifts from its upper neighbour, driven by a compare with the incoming score; K instances form the list.

Verification
REQ-036 Scenario: start, then scores 5,9,-3,9(last) with IDs 1..4 and K=8 -> 4 results: (9,id2),(9,id4),(5,id1),(-3,id3); res_last on rank 3; done pulses once.
REQ-037 Scenario: start, then 20 beats with scores 0..19 ascending, last on the final beat, K=8 -> results 19..12 in order; ranks 0..7.
REQ-038 Scenario: during DRAIN, hold res_ready=0 for 5 cycles -> entry and rank stable; with res_ready then held high, remaining entries transfer at one per cycle.
REQ-039 Scenario: start mid-COLLECT after 3 beats, then score 7 (last) -> a single result (7); no done pulse from the aborted query.
REQ-040 Scenario: rst asserted in DRAIN -> next cycle busy=0 and res_valid=0; a following query behaves as fresh.
REQ-041 Scenario (STATS_EN defined): 2 valid_in beats in IDLE, then a 4-beat query -> stat_seen=4, stat_dropped=0 after start; 3 beats during DRAIN -> stat_dropped=3.
